// File: rtl/dot_product_accumulator_if.sv
// Handshake bundle between the multiplier output, the dot-product accumulator
// and the result consumer.
interface dot_product_accumulator_if #(
   parameter int WIDTH      = 8,
   parameter int VEC_LEN    = 16,
   parameter int PROD_WIDTH = 2*WIDTH,
   parameter int ACC_WIDTH  = PROD_WIDTH + $clog2(VEC_LEN)
);
   logic                  start;
   logic                  prod_valid;
   logic [PROD_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]  sum;
   logic                  sum_valid;
   logic                  sum_ack;
   logic                  busy;
   logic                  err;

   modport master (
      output start, prod_valid, prod, sum_ack,
      input  sum, sum_valid, busy, err
   );

   modport slave (
      input  start, prod_valid, prod, sum_ack,
      output sum, sum_valid, busy, err
   );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums VEC_LEN multiplier products into one unsigned dot product and holds it
// under a valid/ack handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; stray products are dropped and flag err
// ACC     | accepting products, one per prod_valid, gaps allowed
// DONE    | sum presented with sum_valid until sum_ack
module dot_product_accumulator #(
   parameter int WIDTH      = 8,
   parameter int VEC_LEN    = 16,
   parameter int PROD_WIDTH = 2*WIDTH,
   parameter int ACC_WIDTH  = PROD_WIDTH + $clog2(VEC_LEN)
) (
   input logic                     clk,
   input logic                     reset,
   dot_product_accumulator_if.slave bus
);
   localparam int CNT_W = $clog2(VEC_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]           state;
   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_W-1:0]     count;
   logic [ACC_WIDTH-1:0] sum_r;
   logic                 sum_valid_r;
   logic                 busy_r;
   logic                 err_r;
   logic [ACC_WIDTH-1:0] prod_ext;
   logic [ACC_WIDTH-1:0] acc_next;

   assign prod_ext = ACC_WIDTH'(bus.prod);
   assign acc_next = acc + prod_ext;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         acc         <= '0;
         count       <= '0;
         sum_r       <= '0;
         sum_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.prod_valid) err_r <= 1'b1;
               if (bus.start) begin
                  state  <= ST_ACC;
                  acc    <= '0;
                  count  <= '0;
                  busy_r <= 1'b1;
               end
            end
            ST_ACC: begin
               if (bus.prod_valid) begin
                  acc   <= acc_next;
                  count <= count + 1'b1;
                  if (count == LAST_IDX) begin
                     sum_r       <= acc_next;
                     sum_valid_r <= 1'b1;
                     state       <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (bus.prod_valid) err_r <= 1'b1;
               if (bus.sum_ack) begin
                  sum_valid_r <= 1'b0;
                  // ack with start restarts without passing through IDLE
                  if (bus.start) begin
                     state <= ST_ACC;
                     acc   <= '0;
                     count <= '0;
                  end else begin
                     state  <= ST_IDLE;
                     busy_r <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sum       = sum_r;
   assign bus.sum_valid = sum_valid_r;
   assign bus.busy      = busy_r;
   assign bus.err       = err_r;
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator: table of product runs plus
// hand sequences for ack delay, stray products, back-to-back runs and reset.
module tb_dot_product_accumulator;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   logic [19:0] sb_q[$];

   dot_product_accumulator_if #(.WIDTH(8), .VEC_LEN(16)) bus ();

   dot_product_accumulator #(.WIDTH(8), .VEC_LEN(16)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] base;
      logic [15:0] step;
      int          max_gap;
      logic [19:0] exp_sum;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_result(input string name);
      logic [19:0] exp;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got result %0h expected none queued", name, bus.sum);
      end else begin
         exp = sb_q.pop_front();
         check(name, 32'(bus.sum), 32'(exp));
      end
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("busy_after_start", 32'(bus.busy), 32'd1);
   endtask

   task automatic feed(input logic [15:0] base, input logic [15:0] step, input int max_gap);
      for (int i = 0; i < 16; i++) begin
         int g;
         g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int k = 0; k < g; k++) begin
            bus.prod_valid = 1'b0;
            bus.prod = 16'($urandom);
            tick();
         end
         bus.prod_valid = 1'b1;
         bus.prod = base + 16'(i) * step;
         if (i == 15) check("no_early_valid", 32'(bus.sum_valid), 32'd0);
         tick();
      end
      bus.prod_valid = 1'b0;
      check("valid_latency", 32'(bus.sum_valid), 32'd1);
   endtask

   task automatic ack_to_idle();
      bus.sum_ack = 1'b1;
      tick();
      bus.sum_ack = 1'b0;
      check("ack_valid_low", 32'(bus.sum_valid), 32'd0);
      check("ack_busy_low", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'd1,    16'd0,   0, 20'd16};
      vecs[1] = '{16'hFFFF, 16'd0,   0, 20'hFFFF0};
      vecs[2] = '{16'd1,    16'd1,   3, 20'd136};
      vecs[3] = '{16'd2,    16'd0,   0, 20'd32};
      vecs[4] = '{16'd3,    16'd0,   1, 20'd48};
      vecs[5] = '{16'd1000, 16'd100, 2, 20'd28000};

      reset = 1'b1;
      bus.start = 1'b0;
      bus.prod_valid = 1'b0;
      bus.prod = '0;
      bus.sum_ack = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_valid", 32'(bus.sum_valid), 32'd0);
      check("rst_sum", 32'(bus.sum), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);

      for (int v = 0; v < 6; v++) begin
         sb_q.push_back(vecs[v].exp_sum);
         do_start();
         feed(vecs[v].base, vecs[v].step, vecs[v].max_gap);
         check_result("table_sum");
         check("table_err", 32'(bus.err), 32'd0);
         ack_to_idle();
         check("sum_retained", 32'(bus.sum), 32'(vecs[v].exp_sum));
      end

      // stray product while idle
      bus.prod_valid = 1'b1;
      bus.prod = 16'd99;
      tick();
      bus.prod_valid = 1'b0;
      check("idle_drop_err", 32'(bus.err), 32'd1);
      check("idle_drop_novalid", 32'(bus.sum_valid), 32'd0);
      sb_q.push_back(20'd32);
      do_start();
      feed(16'd2, 16'd0, 0);
      check_result("after_drop_sum");
      ack_to_idle();

      // ack delayed: result holds, start alone ignored, product in DONE flagged
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb_q.push_back(20'd136);
      do_start();
      feed(16'd1, 16'd1, 3);
      check_result("gap_sum");
      for (int d = 0; d < 5; d++) begin
         bus.start = (d == 1);
         bus.prod_valid = (d == 3);
         bus.prod = 16'd7;
         tick();
         check("hold_sum", 32'(bus.sum), 32'd136);
         check("hold_valid", 32'(bus.sum_valid), 32'd1);
         check("hold_busy", 32'(bus.busy), 32'd1);
      end
      bus.start = 1'b0;
      bus.prod_valid = 1'b0;
      check("done_drop_err", 32'(bus.err), 32'd1);
      ack_to_idle();

      // ack and start together: zero-bubble restart
      sb_q.push_back(20'd16);
      sb_q.push_back(20'd48);
      do_start();
      feed(16'd1, 16'd0, 0);
      check_result("b2b_first");
      bus.sum_ack = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.sum_ack = 1'b0;
      bus.start = 1'b0;
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_valid_low", 32'(bus.sum_valid), 32'd0);
      check("b2b_first_kept", 32'(bus.sum), 32'd16);
      feed(16'd3, 16'd0, 0);
      check_result("b2b_second");
      ack_to_idle();

      // reset in the middle of a run
      do_start();
      for (int i = 0; i < 7; i++) begin
         bus.prod_valid = 1'b1;
         bus.prod = 16'd5;
         tick();
      end
      bus.prod_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_sum", 32'(bus.sum), 32'd0);
      check("midrst_valid", 32'(bus.sum_valid), 32'd0);
      check("midrst_err", 32'(bus.err), 32'd0);
      sb_q.push_back(20'd16);
      do_start();
      feed(16'd1, 16'd0, 0);
      check_result("midrst_sum_after");
      ack_to_idle();

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
